logic_op_arbiter: RTL and testbench

Shares a single 32-bit bitwise logic unit (AND/OR/NOR, optional XOR) between two requesters. Arbitration is round-robin. Each requester uses a valid/ready handshake, and one registered result is returned per accepted request, tagged with the requester ID. The block sits between the two instruction-issue front ends and the shared logic datapath, which holds the per-operation units such as the 32-bit OR operator.

---
 rtl/logic_op_arbiter_if.sv | 41 ++++
 rtl/logic_op_arbiter.sv | 140 ++++++++++++++
 tb/tb_logic_op_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_op_arbiter_if.sv
// Bus bundle for logic_op_arbiter: two requester ports and one result port.
// master = issue/consume side (front ends and result consumer), slave = arbiter.
interface logic_op_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_id, res_err,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_id, res_err,
        input  res_ready
    );
endinterface

// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: shares one bitwise logic unit (AND/OR/NOR, optional XOR)
// between two requesters with round-robin arbitration and a registered,
// ID-tagged result held until the consumer accepts it.
// Optional feature macro: LOGIC_ARB_XOR_EN enables opcode 10 (XOR); without
// it opcode 10 returns zero data with res_err set and no XOR logic exists.
module logic_op_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    logic_op_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    state_t           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       op_q,         op_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic             id_q,         id_d;
    logic [WIDTH-1:0] res_data_q,   res_data_d;
    logic             res_id_q,     res_id_d;
    logic             res_err_q,    res_err_d;

    logic grant_valid;
    logic grant_id;
    logic ready0;
    logic ready1;

    // Round-robin pick: on contention the port that did not win last time goes.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == IDLE && !rst) begin
            grant_valid = bus.req0_valid | bus.req1_valid;
            if (bus.req0_valid && bus.req1_valid) begin
                grant_id = ~last_grant_q;
            end else begin
                grant_id = bus.req1_valid;
            end
        end
        ready0 = grant_valid && !grant_id;
        ready1 = grant_valid &&  grant_id;
    end

    // Next-state logic: latch the granted payload, compute once, hold result.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        res_err_d    = res_err_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    op_d         = grant_id ? bus.req1_op : bus.req0_op;
                    a_d          = grant_id ? bus.req1_a  : bus.req0_a;
                    b_d          = grant_id ? bus.req1_b  : bus.req0_b;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_id_d  = id_q;
                res_err_d = 1'b0;
                case (op_q)
                    OP_AND: res_data_d = a_q & b_q;
                    OP_OR:  res_data_d = a_q | b_q;
                    OP_NOR: res_data_d = ~(a_q | b_q);
                    OP_XOR: begin
`ifdef LOGIC_ARB_XOR_EN
                        res_data_d = a_q ^ b_q;
                        res_err_d  = 1'b0;
`else
                        res_data_d = '0;
                        res_err_d  = 1'b1;
`endif
                    end
                    default: res_data_d = '0;
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            res_err_q    <= res_err_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = (state_q == DONE);
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_err    = res_err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Testbench for logic_op_arbiter: directed vectors with literal expectations
// plus a transaction-level reference model compared on every cycle.
module tb_logic_op_arbiter;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic_op_arbiter_if #(.WIDTH(32)) bus ();

    logic_op_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results straight from the opcode table: {err, data}.
    function automatic logic [32:0] golden(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'b00:   golden = {1'b0, a & b};
            2'b01:   golden = {1'b0, a | b};
            2'b11:   golden = {1'b0, ~(a | b)};
`ifdef LOGIC_ARB_XOR_EN
            default: golden = {1'b0, a ^ b};
`else
            default: golden = {1'b1, 32'h0};
`endif
        endcase
    endfunction

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A transaction is granted when the unit is free, becomes visible one
    // edge later, and retires on the first visible cycle with res_ready.
    logic        m_armed = 1'b0;
    logic        m_busy  = 1'b0;
    logic        m_shown = 1'b0;
    logic        m_last  = 1'b1;
    logic [32:0] m_pend  = '0;
    logic        m_pid   = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_id    = 1'b0;
    logic        m_err   = 1'b0;

    logic exp_any, exp_id, exp_ready0, exp_ready1;
    assign exp_any    = !rst && m_armed && !m_busy && (bus.req0_valid || bus.req1_valid);
    assign exp_id     = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
    assign exp_ready0 = exp_any && !exp_id;
    assign exp_ready1 = exp_any &&  exp_id;

    // Model advance at each rising edge from the stimulus seen in that cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_armed <= 1'b1;
            m_busy  <= 1'b0;
            m_shown <= 1'b0;
            m_last  <= 1'b1;
            m_data  <= '0;
            m_id    <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_armed) begin
            if (exp_any) begin
                m_pend <= exp_id ? golden(bus.req1_op, bus.req1_a, bus.req1_b)
                                 : golden(bus.req0_op, bus.req0_a, bus.req0_b);
                m_pid  <= exp_id;
                m_last <= exp_id;
                m_busy <= 1'b1;
            end else if (m_busy && !m_shown) begin
                m_shown <= 1'b1;
                m_data  <= m_pend[31:0];
                m_err   <= m_pend[32];
                m_id    <= m_pid;
            end else if (m_shown && bus.res_ready) begin
                m_shown <= 1'b0;
                m_busy  <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle compare of the DUT against the model on the falling edge.
    always @(negedge clk) begin
        if (m_armed) begin
            checkBit("cyc_req0_ready", bus.req0_ready, exp_ready0);
            checkBit("cyc_req1_ready", bus.req1_ready, exp_ready1);
            checkBit("cyc_res_valid",  bus.res_valid,  m_shown);
            if (m_shown) begin
                checkOutput("cyc_res_data", bus.res_data, m_data);
                checkBit("cyc_res_id",  bus.res_id,  m_id);
                checkBit("cyc_res_err", bus.res_err, m_err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus(input int port, input logic valid, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            bus.req0_valid = valid; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = valid; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Wait at falling edges for req0_ready (0), req1_ready (1) or res_valid (2).
    task automatic waitFor(input int which, input string name, output int cycles);
        cycles = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((which == 0 && bus.req0_ready) || (which == 1 && bus.req1_ready) ||
                (which == 2 && bus.res_valid)) begin
                cycles = i;
                return;
            end
        end
        checkBit({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 1'b0, 2'b00, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    localparam logic [31:0] OPA = 32'h54524000;
    localparam logic [31:0] OPB = 32'h45920000;

    int   cyc;
    int   grants[$];
    logic [31:0] rdata[$];
    logic        rid[$];
    logic [31:0] held;

    initial begin
        rst = 1'b1;
        bus.res_ready = 1'b1;
        applyStimulus(0, 1'b0, 2'b00, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        checkBit("rst_req0_ready", bus.req0_ready, 1'b0);
        checkBit("rst_req1_ready", bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkBit("rst_res_valid", bus.res_valid, 1'b0);
        checkOutput("rst_res_data", bus.res_data, 32'h0);
        checkBit("rst_res_id",  bus.res_id,  1'b0);
        checkBit("rst_res_err", bus.res_err, 1'b0);

        // OR with latency and single-cycle ready
        $display("[TB] OR / latency");
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 2'b01, OPA, OPB);
        waitFor(0, "or_grant", cyc);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'b01, OPA, OPB);
        @(negedge clk);
        checkBit("or_ready_one_cycle", bus.req0_ready, 1'b0);
        waitFor(2, "or_result", cyc);
        checkOutput("or_latency", 32'(cyc + 2), 32'd2);
        checkOutput("or_data", bus.res_data, 32'h55D24000);
        checkBit("or_id", bus.res_id, 1'b0);

        // contention from a fresh reset: expect grants 0,1,0
        $display("[TB] contention / round-robin");
        doReset();
        applyStimulus(0, 1'b1, 2'b00, OPA, OPB);
        applyStimulus(1, 1'b1, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 40 && grants.size() < 3; i++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            if (bus.res_valid) begin
                rdata.push_back(bus.res_data);
                rid.push_back(bus.res_id);
            end
        end
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'b00, OPA, OPB);
        applyStimulus(1, 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkOutput("rr_grant_count", 32'(grants.size()), 32'd3);
        checkOutput("rr_result_count", 32'(rdata.size()), 32'd2);
        if (grants.size() == 3) begin
            checkOutput("rr_grant0", 32'(grants[0]), 32'd0);
            checkOutput("rr_grant1", 32'(grants[1]), 32'd1);
            checkOutput("rr_grant2", 32'(grants[2]), 32'd0);
        end
        if (rdata.size() == 2) begin
            checkOutput("rr_data0", rdata[0], 32'h44120000);
            checkBit("rr_id0", rid[0], 1'b0);
            checkOutput("rr_data1", rdata[1], 32'hFFFFFFFF);
            checkBit("rr_id1", rid[1], 1'b1);
        end
        waitFor(2, "rr_third", cyc);
        checkOutput("rr_data2", bus.res_data, 32'h44120000);

        // backpressure, then NOR with payload change after grant
        $display("[TB] backpressure / NOR");
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        applyStimulus(0, 1'b1, 2'b01, OPA, OPB);
        waitFor(0, "bp_grant", cyc);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'b01, OPA, OPB);
        applyStimulus(1, 1'b1, 2'b11, 32'h0, 32'h0);
        waitFor(2, "bp_result", cyc);
        held = bus.res_data;
        checkOutput("bp_data", held, 32'h55D24000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBit("bp_valid_held", bus.res_valid, 1'b1);
            checkOutput("bp_data_stable", bus.res_data, held);
            checkBit("bp_no_ready1", bus.req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        checkBit("bp_valid_last", bus.res_valid, 1'b1);
        checkBit("bp_no_ready_last", bus.req1_ready, 1'b0);
        @(negedge clk);
        checkBit("bp_valid_fall", bus.res_valid, 1'b0);
        checkBit("bp_next_grant", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 2'b11, 32'hFFFFFFFF, 32'h0);
        waitFor(2, "nor_result", cyc);
        checkOutput("nor_data", bus.res_data, 32'hFFFFFFFF);
        checkBit("nor_id", bus.res_id, 1'b1);
        checkBit("nor_err", bus.res_err, 1'b0);

        // opcode 10: XOR when enabled, error otherwise
        $display("[TB] opcode 10");
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 2'b10, OPA, OPB);
        waitFor(0, "xor_grant", cyc);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'b10, OPA, OPB);
        waitFor(2, "xor_result", cyc);
`ifdef LOGIC_ARB_XOR_EN
        checkOutput("xor_data", bus.res_data, 32'h11C04000);
        checkBit("xor_err", bus.res_err, 1'b0);
`else
        checkOutput("xor_data", bus.res_data, 32'h0);
        checkBit("xor_err", bus.res_err, 1'b1);
`endif

        // reset while the operation is executing
        $display("[TB] reset mid-op");
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 2'b01, OPA, OPB);
        waitFor(0, "mid_grant", cyc);
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 1'b0, 2'b01, OPA, OPB);
        @(negedge clk);
        checkBit("mid_valid_in_rst", bus.res_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("mid_no_result", bus.res_valid, 1'b0);
        end
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 2'b00, OPA, OPB);
        applyStimulus(1, 1'b1, 2'b01, OPA, OPB);
        @(negedge clk);
        checkBit("mid_port0_pref", bus.req0_ready, 1'b1);
        checkBit("mid_port1_wait", bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'b00, OPA, OPB);
        applyStimulus(1, 1'b0, 2'b01, OPA, OPB);
        waitFor(2, "mid_result", cyc);
        checkOutput("mid_data", bus.res_data, 32'h44120000);
        checkBit("mid_id", bus.res_id, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
